// File: rtl/ball_collision.sv
// Pong ball collision classifier: ball vs. ceiling, floor, back wall, paddle and net.
// Latency: one clock. Inputs are sampled on a rising Clk edge and all outputs are registered.
// Backpressure: none. A new classification is produced every cycle and nothing is stalled.
module ball_collision #(
  parameter logic [9:0] CEIL_Y  = 10'd60,
  parameter logic [9:0] FLOOR_Y = 10'd400,
  parameter logic [9:0] BACK_X  = 10'd20,
  parameter logic [9:0] PAD_X   = 10'd595,
  parameter logic [9:0] NET_X   = 10'd640,
  parameter logic [9:0] PAD_H   = 10'd100
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [9:0] XCord,
  input  logic [9:0] YCord,
  input  logic [9:0] PadTY,
  output logic [5:0] ColSel,
  output logic [2:0] ColOut,
  output logic [9:0] PadBY
);

  localparam logic [2:0] CLS_NONE  = 3'd0;
  localparam logic [2:0] CLS_CEIL  = 3'd1;
  localparam logic [2:0] CLS_FLOOR = 3'd2;
  localparam logic [2:0] CLS_BACK  = 3'd3;
  localparam logic [2:0] CLS_PAD   = 3'd4;
  localparam logic [2:0] CLS_NET   = 3'd5;

  logic [10:0] pad_sum;
  logic [9:0]  pad_by_d, pad_by_q;
  logic [2:0]  col_out_d, col_out_q;
  logic [5:0]  col_sel_d, col_sel_q;
  logic        hit_net, hit_pad, hit_back, hit_floor, hit_ceil;

  // Paddle bottom edge, saturated so a paddle near the screen bottom never wraps to the top.
  always_comb begin
    pad_sum  = {1'b0, PadTY} + {1'b0, PAD_H};
    pad_by_d = pad_sum[10] ? 10'd1023 : pad_sum[9:0];
  end

  // Hit tests against the same-cycle paddle bottom edge, then resolve by fixed priority.
  always_comb begin
    hit_net   = (XCord >= NET_X);
    hit_pad   = (XCord >= PAD_X) && (XCord < NET_X) &&
                (YCord >= PadTY) && (YCord <= pad_by_d);
    hit_back  = (XCord <= BACK_X);
    hit_floor = (YCord >= FLOOR_Y);
    hit_ceil  = (YCord <= CEIL_Y);

    col_out_d = CLS_NONE;
    if (hit_net)        col_out_d = CLS_NET;
    else if (hit_pad)   col_out_d = CLS_PAD;
    else if (hit_back)  col_out_d = CLS_BACK;
    else if (hit_floor) col_out_d = CLS_FLOOR;
    else if (hit_ceil)  col_out_d = CLS_CEIL;

    col_sel_d = 6'd1 << col_out_d;
  end

  // Output registers; reset puts the classifier in the "none" class.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_out_q <= CLS_NONE;
      col_sel_q <= 6'b000001;
      pad_by_q  <= 10'd0;
    end else begin
      col_out_q <= col_out_d;
      col_sel_q <= col_sel_d;
      pad_by_q  <= pad_by_d;
    end
  end

  assign ColOut = col_out_q;
  assign ColSel = col_sel_q;
  assign PadBY  = pad_by_q;

endmodule

// File: tb/tb_ball_collision.sv
// Bench for ball_collision: directed vectors with literal expectations plus a
// per-cycle comparison against a plain-arithmetic model of the collision rules.
module tb_ball_collision;

  logic       clk;
  logic       rst_n;
  logic [9:0] x, y, pt;
  logic [5:0] col_sel;
  logic [2:0] col_out;
  logic [9:0] pad_by;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  int exp_cls;
  int exp_pb;

  ball_collision dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .XCord (x),
    .YCord (y),
    .PadTY (pt),
    .ColSel(col_sel),
    .ColOut(col_out),
    .PadBY (pad_by)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Paddle bottom: top + 100, clipped at the last pixel row.
  function automatic int model_pb(int t);
    int b;
    b = t + 100;
    if (b > 1023) b = 1023;
    return b;
  endfunction

  // Collision class from the court rules, highest priority first.
  function automatic int model_cls(int xx, int yy, int t);
    int b;
    b = model_pb(t);
    if (xx >= 640) return 5;
    if (xx >= 595 && yy >= t && yy <= b) return 4;
    if (xx <= 20) return 3;
    if (yy >= 400) return 2;
    if (yy <= 60) return 1;
    return 0;
  endfunction

  task automatic check(string name, int act, int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Model state: what the registered outputs must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cls <= 0;
      exp_pb  <= 0;
    end else begin
      exp_cls <= model_cls(int'(x), int'(y), int'(pt));
      exp_pb  <= model_pb(int'(pt));
    end
  end

  // Every-cycle comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_colout", int'(col_out), exp_cls);
      check("model_colsel", int'(col_sel), 1 << exp_cls);
      check("model_padby",  int'(pad_by),  exp_pb);
    end
  end

  // Drive one vector, let one edge pass, and check hand-computed results.
  task automatic vec(string name, int xx, int yy, int t, int ecls, int epb);
    @(negedge clk);
    x  = 10'(xx);
    y  = 10'(yy);
    pt = 10'(t);
    @(posedge clk);
    #1;
    check({name, "_colout"}, int'(col_out), ecls);
    check({name, "_colsel"}, int'(col_sel), 1 << ecls);
    check({name, "_padby"},  int'(pad_by),  epb);
  endtask

  task automatic check_reset(string name);
    check({name, "_colout"}, int'(col_out), 0);
    check({name, "_colsel"}, int'(col_sel), 1);
    check({name, "_padby"},  int'(pad_by),  0);
  endtask

  initial begin
    rst_n = 1;
    x = 10'd610; y = 10'd135; pt = 10'd65;
    #1 rst_n = 0;
    #1;
    check_reset("reset_async");
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_held_clock");
    @(negedge clk);
    rst_n = 1;

    vec("paddle_mid",      610, 135, 65,  4, 165);
    vec("ceiling",         200, 60,  65,  1, 165);
    vec("floor",           200, 400, 65,  2, 165);
    vec("open_y61",        200, 61,  65,  0, 165);
    vec("corner_back",     0,   0,   65,  3, 165);
    vec("back_x20",        20,  200, 65,  3, 165);
    vec("open_x21",        21,  200, 65,  0, 165);
    vec("net",             640, 200, 65,  5, 165);
    vec("paddle_miss",     595, 200, 65,  0, 165);
    vec("paddle_bottom",   595, 165, 65,  4, 165);
    vec("paddle_below",    595, 166, 65,  0, 165);
    vec("paddle_top",      594, 65,  65,  0, 165);
    vec("paddle_topedge",  639, 65,  65,  4, 165);
    vec("paddle_above",    600, 64,  65,  0, 165);
    vec("paddle_ceil",     600, 10,  0,   4, 100);
    vec("pad_miss_floor",  600, 450, 65,  2, 165);
    vec("net_corner",      700, 1023, 900, 5, 1000);
    vec("sat_padby",       600, 1010, 1000, 4, 1023);
    vec("sat_bottom_row",  600, 1023, 1000, 4, 1023);
    vec("pad_exact_1023",  600, 1023, 923, 4, 1023);

    // Mid-stream reset: asynchronous clear, then resume on the first edge after release.
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check_reset("reset_mid");
    @(posedge clk);
    #1;
    check_reset("reset_mid_held");
    @(negedge clk);
    rst_n = 1;
    x = 10'd610; y = 10'd135; pt = 10'd65;
    #1;
    check_reset("reset_release_noedge");
    @(posedge clk);
    #1;
    check("resume_colout", int'(col_out), 4);
    check("resume_colsel", int'(col_sel), 6'b010000);
    check("resume_padby",  int'(pad_by),  165);

    // Pseudo-random sweep checked only by the model process.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      x  = 10'($urandom_range(0, 1023));
      y  = 10'($urandom_range(0, 1023));
      pt = 10'($urandom_range(0, 1023));
    end
    @(negedge clk);
    @(negedge clk);
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
